// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its hazard helper.
// Holds the FSM state encoding and the architectural zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the operands in ID.
// Kept separate so the forwarding unit can reuse the same compare.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rd_i,
    input  logic [4:0] ifid_rs1_i,
    input  logic [4:0] ifid_rs2_i,
    output logic       load_use_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = idex_memread_i
                      && (idex_rd_i != REG_X0)
                      && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// whole-pipeline freeze during outstanding data-memory accesses, timeout and stall counting.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   idex_memread_i,
    input  logic [4:0]             idex_rd_i,
    input  logic [4:0]             ifid_rs1_i,
    input  logic [4:0]             ifid_rs2_i,
    input  logic                   branch_taken_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ack_i,
    output logic                   pc_we_o,
    output logic                   ifid_we_o,
    output logic                   ifid_flush_o,
    output logic                   idex_we_o,
    output logic                   idex_flush_o,
    output logic                   exmem_we_o,
    output logic                   memwb_we_o,
    output logic                   timeout_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_t                 state_reg;
    logic [TO_W-1:0]        to_cnt_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    logic                   freeze;
    logic                   load_use;

    hazard_detect u_hazard_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .load_use_o     (load_use)
    );

    // A same-cycle ack is a cache hit, so it never freezes the pipe.
    assign freeze = ((state_reg == ST_MEM_WAIT) && !dmem_ack_i)
                  || ((state_reg == ST_IDLE) && dmem_req_i && !dmem_ack_i)
                  || (state_reg == ST_ERROR);

    always_comb begin
        pc_we_o      = 1'b0;
        ifid_we_o    = 1'b0;
        ifid_flush_o = 1'b0;
        idex_we_o    = 1'b0;
        idex_flush_o = 1'b0;
        exmem_we_o   = 1'b0;
        memwb_we_o   = 1'b0;
        if (!rst_i && !freeze) begin
            idex_we_o  = 1'b1;
            exmem_we_o = 1'b1;
            memwb_we_o = 1'b1;
            if (load_use) begin
                // Hold PC and IF/ID, insert a bubble; ID re-evaluates any branch next cycle.
                idex_flush_o = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    assign timeout_o   = !rst_i && (state_reg == ST_ERROR);
    assign stall_cnt_o = rst_i ? '0 : stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            to_cnt_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (!pc_we_o && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            unique case (state_reg)
                ST_IDLE: begin
                    if (dmem_req_i && !dmem_ack_i) begin
                        state_reg  <= ST_MEM_WAIT;
                        to_cnt_reg <= TO_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        state_reg  <= ST_IDLE;
                        to_cnt_reg <= '0;
                    end else if (to_cnt_reg == TO_W'(MEM_TIMEOUT)) begin
                        state_reg <= ST_ERROR;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    to_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed plan cases then random traffic,
// two instances (wide and 3-bit stall counter) checked against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;
    localparam int SAT_MAX = 7;
    localparam int CNT_MAX = 65535;

    logic       clk = 1'b0;
    logic       rst, memread, br, req, ack;
    logic [4:0] rd, rs1, rs2;

    logic        pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_we, tmo;
    logic [15:0] scnt;
    logic        s_pc_we, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_fl, s_exmem_we, s_memwb_we, s_tmo;
    logic [2:0]  s_scnt;

    typedef struct {
        logic [7:0] ctrl;
        int         stall;
        int         stall_sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    // Reference model state: pending memory access, cycles waited, sticky error, stall counts.
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_err     = 0;
    int m_cnt     = 0;
    int m_cnt_sat = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8), .STALL_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rd_i(rd),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .branch_taken_i(br),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_fl),
        .idex_we_o(idex_we), .idex_flush_o(idex_fl), .exmem_we_o(exmem_we),
        .memwb_we_o(memwb_we), .timeout_o(tmo), .stall_cnt_o(scnt)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(3), .STALL_CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rd_i(rd),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .branch_taken_i(br),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_we_o(s_pc_we), .ifid_we_o(s_ifid_we), .ifid_flush_o(s_ifid_fl),
        .idex_we_o(s_idex_we), .idex_flush_o(s_idex_fl), .exmem_we_o(s_exmem_we),
        .memwb_we_o(s_memwb_we), .timeout_o(s_tmo), .stall_cnt_o(s_scnt)
    );

    // Drive one cycle of inputs and queue what the pipeline controls must look like.
    task automatic drive(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic b, input logic rq, input logic ak);
        exp_t e;
        bit   frz, lu;
        @(posedge clk);
        #1;
        rst = r; memread = mr; rd = d; rs1 = s1; rs2 = s2; br = b; req = rq; ack = ak;
        if (r) begin
            e.ctrl = 8'b0; e.stall = 0; e.stall_sat = 0;
            m_waiting = 0; m_waited = 0; m_err = 0; m_cnt = 0; m_cnt_sat = 0;
        end else begin
            frz = m_err || (m_waiting && !ak) || (!m_waiting && rq && !ak);
            lu  = mr && (d != 5'd0) && (d == s1 || d == s2);
            //        pc ifwe iffl exwe exfl mewe wbwe tmo
            if (frz)     e.ctrl = {7'b0000000, m_err};
            else if (lu) e.ctrl = 8'b0_0_0_1_1_1_1_0;
            else if (b)  e.ctrl = 8'b1_1_1_1_0_1_1_0;
            else         e.ctrl = 8'b1_1_0_1_0_1_1_0;
            e.stall     = m_cnt;
            e.stall_sat = m_cnt_sat;
            if (frz || lu) begin
                m_cnt     = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_cnt_sat = (m_cnt_sat < SAT_MAX) ? m_cnt_sat + 1 : SAT_MAX;
            end
            if (m_err) begin
                m_err = 1;
            end else if (m_waiting) begin
                if (ak) begin
                    m_waiting = 0; m_waited = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_waiting = 0; m_err = 1;
                end else begin
                    m_waited++;
                end
            end else if (rq && !ak) begin
                m_waiting = 1; m_waited = 1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the controls are live, so pop one expectation per cycle.
    initial begin : monitor
        exp_t e;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if ({pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_we, tmo} != e.ctrl) begin
                    failures++;
                    $display("FAIL ctrl cyc=%0d got=%b exp=%b", cyc,
                             {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_we, tmo}, e.ctrl);
                end
                if (int'(scnt) != e.stall) begin
                    failures++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, scnt, e.stall);
                end
                if ({s_pc_we, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_fl, s_exmem_we, s_memwb_we, s_tmo} != e.ctrl) begin
                    failures++;
                    $display("FAIL ctrl_sat cyc=%0d got=%b exp=%b", cyc,
                             {s_pc_we, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_fl, s_exmem_we, s_memwb_we, s_tmo},
                             e.ctrl);
                end
                if (int'(s_scnt) != e.stall_sat) begin
                    failures++;
                    $display("FAIL stall_cnt_sat cyc=%0d got=%0d exp=%0d", cyc, s_scnt, e.stall_sat);
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        int err_cycles;
        rst = 1'b1; memread = 1'b0; rd = '0; rs1 = '0; rs2 = '0; br = 1'b0; req = 1'b0; ack = 1'b0;
        // Directed plan cases.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 5, 0, 0, 0, 0);      // load-use on rs1
        drive(0, 1, 0, 0, 0, 0, 0, 0);      // load to x0
        drive(0, 0, 0, 0, 0, 1, 0, 0);      // branch flush
        drive(0, 1, 5, 1, 5, 1, 0, 0);      // load-use beats branch
        drive(0, 0, 0, 0, 0, 0, 0, 1);      // stray ack
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);      // ack ends wait
        drive(0, 0, 0, 0, 0, 0, 1, 1);      // hit
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (10) drive(0, 0, 0, 0, 0, 1, 0, 0);  // sticky error, counter saturation
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);      // reset mid-wait
        drive(0, 0, 0, 0, 0, 0, 0, 1);      // late ack ignored
        // Random traffic.
        err_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            err_cycles = m_err ? err_cycles + 1 : 0;
            r = (err_cycles > 6) || ($urandom_range(0, 99) < 2);
            drive(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 99) < (m_waiting ? 35 : 20)));
        end
        stim_done = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
